// File: rtl/line_matrix_pkg.sv
// Shared types and config-word layout helpers for the GPO line matrix.
// A config word is {stretch_en, invert, source[SEL_W-1:0]}, with the source in the low bits.
package line_matrix_pkg;

  localparam int SRC_MAX_W = 16;
  localparam int CNT_W     = 16;

  function automatic int sel_width(input int num_in);
    return $clog2(num_in + 1);
  endfunction

  // Written in terms of sel_w so that all three field positions are derived the same way.
  function automatic int CFG_SRC_LSB(input int sel_w);
    return sel_w - sel_w;
  endfunction

  function automatic int CFG_INV_BIT(input int sel_w);
    return sel_w;
  endfunction

  function automatic int CFG_STR_BIT(input int sel_w);
    return sel_w + 1;
  endfunction

  typedef struct packed {
    logic                 stretch_en;
    logic                 invert;
    logic [SRC_MAX_W-1:0] source;
  } cfg_t;

endpackage

// File: rtl/line_matrix_stretch.sv
// Per-output stage: rising-edge detect, pulse-stretch counter, invert, output register.
// reseed marks a cycle in which src has just been switched to a new line, so no edge is taken.
module line_matrix_stretch
  import line_matrix_pkg::*;
#(
  parameter int STRETCH_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic src,
  input  logic stretch_en,
  input  logic invert,
  input  logic reseed,
  output logic out
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(STRETCH_CYCLES - 1);

  logic             src_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;
  logic             level;

  always_comb begin
    rise  = src & ~src_d & ~reseed;
    level = src | (stretch_en & ~reseed & (cnt_q != '0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_d <= 1'b0;
      cnt_q <= '0;
      out   <= 1'b0;
    end else begin
      src_d <= src;
      out   <= level ^ invert;
      if (reseed)
        cnt_q <= '0;
      else if (rise && stretch_en)
        cnt_q <= LOAD;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/line_matrix_v2.sv
// Routes NUM_IN asynchronous GPO lines to NUM_OUT outputs through synchronisers and
// per-output stretch/invert stages, with shadow/active config and a global commit.
module line_matrix_v2
  import line_matrix_pkg::*;
#(
  parameter int NUM_IN         = 8,
  parameter int NUM_OUT        = 9,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  localparam int SEL_W         = sel_width(NUM_IN),
  localparam int CFG_W         = SEL_W + 2,
  localparam int AW            = $clog2((NUM_OUT > 2) ? NUM_OUT : 2)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_IN-1:0] input_lines,
  output logic [NUM_OUT-1:0] output_lines,
  input  logic              cfg_wr,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  output logic [CFG_W-1:0]  cfg_rdata,
  output logic              cfg_err
);

  localparam int SRC_LSB = CFG_SRC_LSB(SEL_W);
  localparam int INV_BIT = CFG_INV_BIT(SEL_W);
  localparam int STR_BIT = CFG_STR_BIT(SEL_W);
  localparam int EXT_W   = 1 << SEL_W;
  localparam logic [CFG_W-1:0] CFG_RESET = {2'b00, SEL_W'(NUM_IN)};

  logic [NUM_IN-1:0] sync_q [SYNC_STAGES];
  logic [CFG_W-1:0]  shadow_q [NUM_OUT];
  logic [CFG_W-1:0]  active_q [NUM_OUT];
  logic [EXT_W-1:0]  synced_ext;
  logic              addr_ok;
  logic [CFG_W-1:0]  rd_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= input_lines;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Source codes at or above NUM_IN land on the zero padding and read as constant 0.
  assign synced_ext = {{(EXT_W - NUM_IN){1'b0}}, sync_q[SYNC_STAGES-1]};

  // cfg_wr and cfg_commit are single-cycle strobes sampled every clock, no back-pressure;
  // a commit copies the shadow as it stood before any write in the same cycle.
  always_comb begin
    addr_ok = int'(cfg_addr) < NUM_OUT;
    rd_next = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (cfg_addr == AW'(i)) rd_next = shadow_q[i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        shadow_q[i] <= CFG_RESET;
        active_q[i] <= CFG_RESET;
      end
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (cfg_commit) active_q[i] <= shadow_q[i];
        if (cfg_wr && cfg_addr == AW'(i)) shadow_q[i] <= cfg_data;
      end
      cfg_rdata <= rd_next;
      if (cfg_wr && !addr_ok)
        cfg_err <= 1'b1;
      else if (cfg_commit)
        cfg_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    logic [CFG_W-1:0] eff_raw;
    cfg_t             eff;
    logic             src_bit;
    logic             reseed;

    // During a commit cycle the incoming config already drives the mux, so the
    // registered output shows the new route from the following cycle.
    always_comb begin
      eff_raw        = cfg_commit ? shadow_q[g] : active_q[g];
      eff            = '0;
      eff.stretch_en = eff_raw[STR_BIT];
      eff.invert     = eff_raw[INV_BIT];
      eff.source     = SRC_MAX_W'(eff_raw[SRC_LSB +: SEL_W]);
      src_bit        = (int'(eff.source) < NUM_IN) ? synced_ext[eff.source[SEL_W-1:0]] : 1'b0;
      reseed         = cfg_commit &&
                       (shadow_q[g][SRC_LSB +: SEL_W] != active_q[g][SRC_LSB +: SEL_W]);
    end

    line_matrix_stretch #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_stretch (
      .clk       (clk),
      .rstn      (rstn),
      .src       (src_bit),
      .stretch_en(eff.stretch_en),
      .invert    (eff.invert),
      .reseed    (reseed),
      .out       (output_lines[g])
    );
  end

endmodule

// File: tb/tb_line_matrix_v2.sv
// Self-checking bench for line_matrix_v2 with default parameters (8 in, 9 out, 2 sync, stretch 16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_line_matrix_v2;

  localparam int NUM_IN         = 8;
  localparam int NUM_OUT        = 9;
  localparam int SYNC_STAGES    = 2;
  localparam int STRETCH_CYCLES = 16;
  localparam int NUM_VEC        = 12;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] input_lines;
  logic [8:0] output_lines;
  logic       cfg_wr;
  logic [3:0] cfg_addr;
  logic [5:0] cfg_data;
  logic       cfg_commit;
  logic [5:0] cfg_rdata;
  logic       cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] in_v;
    logic [8:0] exp_v;
  } vec_t;

  vec_t       vecs [NUM_VEC];
  logic [5:0] route_cfg [NUM_OUT];

  line_matrix_v2 #(
    .NUM_IN        (NUM_IN),
    .NUM_OUT       (NUM_OUT),
    .SYNC_STAGES   (SYNC_STAGES),
    .STRETCH_CYCLES(STRETCH_CYCLES)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .input_lines (input_lines),
    .output_lines(output_lines),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_rdata   (cfg_rdata),
    .cfg_err     (cfg_err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [5:0] d);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    tick(1);
    cfg_commit = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [5:0] d);
    cfg_addr = a;
    tick(1);
    d = cfg_rdata;
  endtask

  // Reference routing: the selected input (or 0 for codes >= NUM_IN), then the invert bit.
  function automatic logic [8:0] route_model(input logic [7:0] in_v);
    logic [8:0] r;
    logic [3:0] s;
    for (int o = 0; o < NUM_OUT; o++) begin
      s    = route_cfg[o][3:0];
      r[o] = ((s < 4'd8) ? in_v[s[2:0]] : 1'b0) ^ route_cfg[o][4];
    end
    return r;
  endfunction

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000 ns");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] rd;
    logic [7:0] in_tab [NUM_VEC];
    int         high;
    int         rises;
    int         first_k;
    logic       prev;

    // reset with all inputs high
    rstn        = 1'b0;
    input_lines = '1;
    cfg_wr      = 1'b0;
    cfg_addr    = '0;
    cfg_data    = '0;
    cfg_commit  = 1'b0;
    tick(2);
    check("reset_outputs", output_lines, 9'h000);
    check("reset_rdata", cfg_rdata, 6'h00);
    check("reset_err", cfg_err, 1'b0);
    rstn = 1'b1;
    tick(6);
    check("idle_inputs_high", output_lines, 9'h000);
    cfg_read(4'd3, rd);
    check("reset_shadow3", rd, 6'h08);

    // out3 <- in5, exact 3-cycle latency, other outputs untouched
    input_lines = '0;
    tick(4);
    cfg_write(4'd3, 6'h05);
    do_commit();
    tick(2);
    check("t2_before", output_lines, 9'h000);
    input_lines[5] = 1'b1;
    tick(1);
    check("t2_lat1", output_lines, 9'h000);
    tick(1);
    check("t2_lat2", output_lines, 9'h000);
    tick(1);
    check("t2_lat3", output_lines, 9'h008);
    input_lines[5] = 1'b0;
    tick(3);
    check("t2_fall", output_lines, 9'h000);

    // full routing table, streamed vectors through the scoreboard queue
    route_cfg = '{6'h02, 6'h15, 6'h07, 6'h05, 6'h00, 6'h08, 6'h18, 6'h11, 6'h0F};
    for (int o = 0; o < NUM_OUT; o++) cfg_write(4'(o), route_cfg[o]);
    do_commit();
    for (int o = 0; o < NUM_OUT; o++) begin
      cfg_read(4'(o), rd);
      check($sformatf("readback%0d", o), rd, route_cfg[o]);
    end
    cfg_read(4'd12, rd);
    check("readback_oob", rd, 6'h00);

    in_tab = '{8'h00, 8'hFF, 8'h24, 8'h81, 8'h02, 8'hA5, 8'h5A, 8'h80, 8'h01, 8'h20, 8'h00, 8'h00};
    in_tab[10] = 8'($urandom_range(0, 255));
    in_tab[11] = 8'($urandom_range(0, 255));
    for (int i = 0; i < NUM_VEC; i++) begin
      vecs[i].in_v  = in_tab[i];
      vecs[i].exp_v = route_model(in_tab[i]);
    end
    for (int i = 0; i < NUM_VEC + 3; i++) begin
      if (i >= 3) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL vec_queue: queue empty at step %0d, expected an entry", i);
        end else begin
          check($sformatf("vec%0d", i - 3), output_lines, exp_q.pop_front());
        end
      end
      if (i < NUM_VEC) begin
        input_lines = vecs[i].in_v;
        exp_q.push_back(vecs[i].exp_v);
      end
      tick(1);
    end

    // out0: stretch on in2
    input_lines = '0;
    tick(4);
    cfg_write(4'd0, 6'h22);
    do_commit();
    tick(2);
    check("t3_idle", output_lines[0], 1'b0);
    input_lines[2] = 1'b1;
    high = 0; rises = 0; prev = 1'b0; first_k = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (k == 0) input_lines[2] = 1'b0;
      if (output_lines[0]) begin
        high++;
        if (first_k < 0) first_k = k;
      end
      if (output_lines[0] && !prev) rises++;
      prev = output_lines[0];
    end
    check("t3_single_high", high, 16);
    check("t3_single_start", first_k, 2);
    check("t3_single_runs", rises, 1);

    input_lines[2] = 1'b1;
    high = 0; rises = 0; prev = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (k == 0)  input_lines[2] = 1'b0;
      if (k == 9)  input_lines[2] = 1'b1;
      if (k == 10) input_lines[2] = 1'b0;
      if (output_lines[0]) high++;
      if (output_lines[0] && !prev) rises++;
      prev = output_lines[0];
    end
    check("t3_retrigger_high", high, 26);
    check("t3_retrigger_runs", rises, 1);

    // out1 constant 1, cfg_err set/hold/clear
    input_lines[5] = 1'b1;
    tick(4);
    check("t4_pre", output_lines[1], 1'b0);
    cfg_write(4'd1, 6'h18);
    check("t4_shadow_only", output_lines[1], 1'b0);
    do_commit();
    check("t4_const1", output_lines[1], 1'b1);
    input_lines[5] = 1'b0;
    tick(4);
    check("t4_const1_hold", output_lines[1], 1'b1);
    cfg_write(4'd9, 6'h3F);
    check("t4_err_set", cfg_err, 1'b1);
    cfg_read(4'd9, rd);
    check("t4_rdata_oob", rd, 6'h00);
    cfg_read(4'd1, rd);
    check("t4_shadow1_intact", rd, 6'h18);
    cfg_wr = 1'b1; cfg_addr = 4'd9; cfg_data = 6'h01; cfg_commit = 1'b1;
    tick(1);
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    check("t4_err_hold", cfg_err, 1'b1);
    do_commit();
    check("t4_err_clear", cfg_err, 1'b0);

    // same-cycle write and commit on out2
    input_lines = 8'h02;
    tick(4);
    check("t5_pre", output_lines[2], 1'b0);
    cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_data = 6'h01; cfg_commit = 1'b1;
    tick(1);
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    tick(2);
    check("t5_old_route", output_lines[2], 1'b0);
    cfg_read(4'd2, rd);
    check("t5_shadow", rd, 6'h01);
    do_commit();
    check("t5_new_route", output_lines[2], 1'b1);

    // out4 switches from in0 (low) to in7 (high) with stretch on: no false edge
    input_lines = 8'h80;
    tick(4);
    check("t6_pre", output_lines[4], 1'b0);
    cfg_write(4'd4, 6'h27);
    do_commit();
    check("t6_switch", output_lines[4], 1'b1);
    input_lines[7] = 1'b0;
    tick(2);
    check("t6_lat2", output_lines[4], 1'b1);
    tick(1);
    check("t6_no_stretch", output_lines[4], 1'b0);
    tick(3);
    check("t6_stays_low", output_lines[4], 1'b0);

    // asynchronous reset in the middle of a stretched pulse
    input_lines = '0;
    tick(4);
    input_lines[2] = 1'b1;
    tick(1);
    input_lines[2] = 1'b0;
    tick(5);
    check("rst_mid_stretch", output_lines[0], 1'b1);
    #2 rstn = 1'b0;
    #1 check("rst_async", output_lines, 9'h000);
    tick(2);
    rstn = 1'b1;
    tick(4);
    check("rst_after", output_lines, 9'h000);
    check("rst_err", cfg_err, 1'b0);
    cfg_read(4'd0, rd);
    check("rst_shadow0", rd, 6'h08);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
